// File: rtl/adc_framer_pkg.sv
// Shared types and constants for the ADC sample framer.
// Frame layout: seq[15:8] seq[7:0] len[15:8] len[7:0], then len big-endian
// samples, then an optional 2-byte drop-count trailer.
package adc_framer_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_HDR0,
    S_HDR1,
    S_HDR2,
    S_HDR3,
    S_DHI,
    S_DLO,
    S_TRL0,
    S_TRL1
  } state_e;

  localparam int HDR_BYTES = 4;
  localparam int TRL_BYTES = 2;

  // Byte positions within the 32-bit header word {seq, len}
  localparam int HDR_SEQ_HI_OFF = 0;
  localparam int HDR_SEQ_LO_OFF = 1;
  localparam int HDR_LEN_HI_OFF = 2;
  localparam int HDR_LEN_LO_OFF = 3;

  function automatic int frame_bytes(input int n_samples, input bit with_trailer);
    return HDR_BYTES + 2 * n_samples + (with_trailer ? TRL_BYTES : 0);
  endfunction

endpackage

// File: rtl/adc_sample_fifo.sv
// Single-clock sample FIFO. The head word is held in a register that is
// refreshed the same cycle it is popped (or written into an empty FIFO), so
// the consumer always sees the current head with no read latency.
module adc_sample_fifo #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             wr_fire, rd_fire;

  // Fullness is judged on the pre-read count, so a write into a full FIFO is
  // dropped even if a read happens in the same cycle.
  always_comb begin
    full      = (count_q == CW'(DEPTH));
    empty     = (count_q == '0);
    wr_fire   = wr_en && !full;
    rd_fire   = rd_en && !empty;
    wr_ptr_d  = wr_ptr_q + AW'(wr_fire);
    rd_ptr_d  = rd_ptr_q + AW'(rd_fire);
    count_d   = count_q + CW'(wr_fire) - CW'(rd_fire);
    // Bypass when the word being written becomes the new head
    rd_data_d = (wr_fire && (wr_ptr_q == rd_ptr_d)) ? wr_data : mem_q[rd_ptr_d];
  end

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_ptr_q] <= wr_data;
  end

  // Pointers, occupancy and registered head word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;
  assign count   = count_q;

endmodule

// File: rtl/adc_sample_framer.sv
// Range-gates ADC samples into a FIFO and emits byte-wide AXI-Stream frames.
// Optional build macro ADC_SAMPLE_FRAMER_STATS_EN appends a 2-byte trailer
// carrying the drop counter snapshot taken at frame start.
//
// state | meaning
// IDLE  | waiting for a full frame or a flush timeout
// HDR0  | seq[15:8]
// HDR1  | seq[7:0]
// HDR2  | len[15:8]
// HDR3  | len[7:0]
// DHI   | high byte of FIFO head
// DLO   | low byte of FIFO head, pops the FIFO
// TRL0  | drop snapshot [15:8] (stats build)
// TRL1  | drop snapshot [7:0]  (stats build)
module adc_sample_framer
  import adc_framer_pkg::*;
#(
  parameter int FIFO_DEPTH    = 1024,
  parameter int FRAME_SAMPLES = 256,
  parameter int FLUSH_TIMEOUT = 125000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        adc_valid,
  input  logic [15:0] adc_data,
  input  logic [15:0] n,
  input  logic [15:0] m,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        overflow,
  output logic [15:0] drop_count
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_e        state_q, state_d;
  logic [15:0]   seq_q, seq_d;
  logic [15:0]   len_q, len_d;
  logic [15:0]   rem_q, rem_d;
  logic [31:0]   tmo_q, tmo_d;
  logic          overflow_q, overflow_d;
  logic [15:0]   drop_cnt_q, drop_cnt_d;
`ifdef ADC_SAMPLE_FRAMER_STATS_EN
  logic [15:0]   snap_q, snap_d;
`endif

  logic          accept, wr_fire, drop, fire, rd_en, start;
  logic [15:0]   fifo_head;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [31:0]   hdr_w;

  adc_sample_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(16)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (accept),
    .wr_data (adc_data),
    .rd_en   (rd_en),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Next-state, stream outputs, timeout and drop bookkeeping
  always_comb begin
    state_d       = state_q;
    seq_d         = seq_q;
    len_d         = len_q;
    rem_d         = rem_q;
    tmo_d         = tmo_q;
    overflow_d    = overflow_q;
    drop_cnt_d    = drop_cnt_q;
`ifdef ADC_SAMPLE_FRAMER_STATS_EN
    snap_d        = snap_q;
`endif
    m_axis_tdata  = 8'h00;
    m_axis_tlast  = 1'b0;
    m_axis_tvalid = (state_q != S_IDLE);
    start         = 1'b0;
    rd_en         = 1'b0;

    accept  = adc_valid && (adc_data >= n) && (adc_data <= m);
    wr_fire = accept && !fifo_full;
    drop    = accept && fifo_full;
    fire    = m_axis_tvalid && m_axis_tready;
    hdr_w   = {seq_q, len_q};

    if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    end

    if (wr_fire) begin
      tmo_d = '0;
    end else if ((state_q == S_IDLE) && !fifo_empty && (FLUSH_TIMEOUT != 0)) begin
      tmo_d = tmo_q + 32'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (32'(fifo_count) >= 32'(FRAME_SAMPLES)) begin
          start = 1'b1;
          len_d = 16'(FRAME_SAMPLES);
        end else if (!fifo_empty && (FLUSH_TIMEOUT != 0) &&
                     (tmo_q >= 32'(FLUSH_TIMEOUT))) begin
          start = 1'b1;
          len_d = 16'(fifo_count);
        end
        if (start) begin
          state_d = S_HDR0;
          rem_d   = len_d;
          tmo_d   = '0;
`ifdef ADC_SAMPLE_FRAMER_STATS_EN
          snap_d  = drop_cnt_q;
`endif
        end
      end
      S_HDR0: begin
        m_axis_tdata = hdr_w[31-8*HDR_SEQ_HI_OFF -: 8];
        if (fire) state_d = S_HDR1;
      end
      S_HDR1: begin
        m_axis_tdata = hdr_w[31-8*HDR_SEQ_LO_OFF -: 8];
        if (fire) state_d = S_HDR2;
      end
      S_HDR2: begin
        m_axis_tdata = hdr_w[31-8*HDR_LEN_HI_OFF -: 8];
        if (fire) state_d = S_HDR3;
      end
      S_HDR3: begin
        m_axis_tdata = hdr_w[31-8*HDR_LEN_LO_OFF -: 8];
        if (fire) state_d = S_DHI;
      end
      S_DHI: begin
        m_axis_tdata = fifo_head[15:8];
        if (fire) state_d = S_DLO;
      end
      S_DLO: begin
        m_axis_tdata = fifo_head[7:0];
        rd_en        = fire;
`ifndef ADC_SAMPLE_FRAMER_STATS_EN
        m_axis_tlast = (rem_q == 16'd1);
`endif
        if (fire) begin
          rem_d = rem_q - 16'd1;
          if (rem_q == 16'd1) begin
`ifdef ADC_SAMPLE_FRAMER_STATS_EN
            state_d = S_TRL0;
`else
            state_d = S_IDLE;
            seq_d   = seq_q + 16'd1;
`endif
          end else begin
            state_d = S_DHI;
          end
        end
      end
`ifdef ADC_SAMPLE_FRAMER_STATS_EN
      S_TRL0: begin
        m_axis_tdata = snap_q[15:8];
        if (fire) state_d = S_TRL1;
      end
      S_TRL1: begin
        m_axis_tdata = snap_q[7:0];
        m_axis_tlast = 1'b1;
        if (fire) begin
          state_d = S_IDLE;
          seq_d   = seq_q + 16'd1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // State and bookkeeping registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      seq_q      <= '0;
      len_q      <= '0;
      rem_q      <= '0;
      tmo_q      <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
`ifdef ADC_SAMPLE_FRAMER_STATS_EN
      snap_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      seq_q      <= seq_d;
      len_q      <= len_d;
      rem_q      <= rem_d;
      tmo_q      <= tmo_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
`ifdef ADC_SAMPLE_FRAMER_STATS_EN
      snap_q     <= snap_d;
`endif
    end
  end

  assign overflow   = overflow_q;
  assign drop_count = drop_cnt_q;

endmodule

// File: tb/tb_adc_sample_framer.sv
// Bench for adc_sample_framer: expected stream bytes are queued as each
// frame's samples are driven and popped by a monitor as bytes are accepted.
module tb_adc_sample_framer;
  import adc_framer_pkg::*;

`ifdef ADC_SAMPLE_FRAMER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        adc_valid = 1'b0;
  logic [15:0] adc_data = '0;
  logic [15:0] n = '0;
  logic [15:0] m = 16'hFFFF;
  logic        m_axis_tready = 1'b0;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        overflow;
  logic [15:0] drop_count;

  adc_sample_framer #(
    .FIFO_DEPTH    (8),
    .FRAME_SAMPLES (4),
    .FLUSH_TIMEOUT (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .adc_valid     (adc_valid),
    .adc_data      (adc_data),
    .n             (n),
    .m             (m),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .overflow      (overflow),
    .drop_count    (drop_count)
  );

  always #4 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [8:0]  exp_q[$];
  logic [15:0] frm_q[$];
  logic [15:0] exp_seq = '0;
  logic [15:0] vals[4];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Queue the expected bytes of one frame built from frm_q
  task automatic push_frame(input logic [15:0] snap);
    int len;
    logic [15:0] s;
    len = frm_q.size();
    exp_q.push_back({1'b0, exp_seq[15:8]});
    exp_q.push_back({1'b0, exp_seq[7:0]});
    exp_q.push_back({1'b0, 8'(len >> 8)});
    exp_q.push_back({1'b0, 8'(len)});
    for (int i = 0; i < len; i++) begin
      s = frm_q.pop_front();
      exp_q.push_back({1'b0, s[15:8]});
      exp_q.push_back({(!STATS && (i == len - 1)), s[7:0]});
    end
    if (STATS) begin
      exp_q.push_back({1'b0, snap[15:8]});
      exp_q.push_back({1'b1, snap[7:0]});
    end
    exp_seq = exp_seq + 16'd1;
  endtask

  task automatic send(input logic [15:0] d);
    adc_valid = 1'b1;
    adc_data  = d;
    @(posedge clk); #1;
    adc_valid = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget, input int keep, input bit rnd);
    int cyc;
    cyc = 0;
    while ((exp_q.size() > keep) && (cyc < budget)) begin
      if (rnd) m_axis_tready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      cyc++;
    end
    chk(tag, 32'(exp_q.size() <= keep), 32'd1);
  endtask

  // Stream monitor: byte scoreboard and hold-under-backpressure check
  logic       stall = 1'b0;
  logic [9:0] held  = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      stall = 1'b0;
    end else begin
      if (stall) chk("hold", {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, held);
      stall = m_axis_tvalid && !m_axis_tready;
      held  = {m_axis_tvalid, m_axis_tlast, m_axis_tdata};
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) chk("extra_byte", 32'(exp_q.size()), 32'd1);
        else chk("byte", {m_axis_tlast, m_axis_tdata}, exp_q.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tlast", m_axis_tlast, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_drops", drop_count, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Full-frame trigger with open bounds
    m_axis_tready = 1'b1;
    n = 16'h0000; m = 16'hFFFF;
    for (int i = 1; i <= 4; i++) frm_q.push_back(16'(i));
    push_frame(16'h0000);
    for (int i = 1; i <= 4; i++) send(16'(i));
    drain("bounds_drain", 100, 0, 1'b0);
    chk("bounds_drops", drop_count, 0);

    // Range gate, then an empty window (n > m), flushed by timeout
    n = 16'h0100; m = 16'h0200;
    frm_q.push_back(16'h0100);
    frm_q.push_back(16'h0200);
    push_frame(16'h0000);
    send(16'h00FF); send(16'h0100); send(16'h0200); send(16'h0201);
    n = 16'h0300; m = 16'h0100;
    send(16'h0180); send(16'h0300);
    chk("range_drops", drop_count, 0);
    drain("range_drain", 100, 0, 1'b0);
    chk("range_overflow", overflow, 0);

    // Timeout flush of a 3-sample partial frame
    n = 16'h0000; m = 16'hFFFF;
    for (int i = 0; i < 3; i++) frm_q.push_back(16'hA001 + 16'(i));
    push_frame(16'h0000);
    for (int i = 0; i < 3; i++) send(16'hA001 + 16'(i));
    repeat (10) @(posedge clk);
    #1;
    chk("flush_early", 32'(exp_q.size()), 32'(frame_bytes(3, STATS)));
    drain("flush_drain", 100, 0, 1'b0);

    // Overflow with the stream stalled
    m_axis_tready = 1'b0;
    for (int i = 0; i < 4; i++) frm_q.push_back(16'h0010 + 16'(i));
    push_frame(16'h0000);
    for (int i = 4; i < 8; i++) frm_q.push_back(16'h0010 + 16'(i));
    push_frame(16'h0004);
    for (int i = 0; i < 12; i++) send(16'h0010 + 16'(i));
    chk("ovf_flag", overflow, 1);
    chk("ovf_drops", drop_count, 4);
    m_axis_tready = 1'b1;
    drain("ovf_drain", 200, 0, 1'b0);
    chk("ovf_drops_after", drop_count, 4);

    // Random backpressure over 100 frames
    for (int f = 0; f < 100; f++) begin
      drain("bp_wait", 2000, frame_bytes(4, STATS), 1'b1);
      for (int i = 0; i < 4; i++) begin
        vals[i] = 16'($urandom_range(0, 65535));
        frm_q.push_back(vals[i]);
      end
      push_frame(16'h0004);
      for (int i = 0; i < 4; i++) send(vals[i]);
    end
    drain("bp_drain", 2000, 0, 1'b1);

    // Reset while presenting the first sample byte
    m_axis_tready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vals[i] = 16'h5A00 + 16'(i);
      frm_q.push_back(vals[i]);
    end
    push_frame(16'h0004);
    for (int i = 0; i < 4; i++) send(vals[i]);
    repeat (3) @(posedge clk);
    #1;
    m_axis_tready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("mid_dhi_byte", {m_axis_tvalid, m_axis_tdata}, {1'b1, vals[0][15:8]});
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tvalid", m_axis_tvalid, 0);
    chk("mid_rst_tlast", m_axis_tlast, 0);
    exp_q.delete();
    exp_seq = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("post_rst_overflow", overflow, 0);
    chk("post_rst_drops", drop_count, 0);
    @(posedge clk); #1;
    chk("post_rst_idle", m_axis_tvalid, 0);
    for (int i = 0; i < 4; i++) frm_q.push_back(16'hC300 + 16'(i));
    push_frame(16'h0000);
    for (int i = 0; i < 4; i++) send(16'hC300 + 16'(i));
    drain("post_rst_drain", 100, 0, 1'b0);

    repeat (4) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
